ram_dp_fifo_ctrl: RTL and testbench

Single-clock FIFO controller that sequences the true dual-port 8Kx2 block RAM (RAM_DP_TRUE, registered address/data-in, unregistered output) as a circular buffer. Port A is the write port and port B is the read port. The block owns the pointers, occupancy count, full/empty flags and error flags, and drives the RAM control pins. It sits between a producer/consumer pair and an external RAM_DP_TRUE instance.

---
 rtl/ram_fifo_pkg.sv | 20 ++
 rtl/ram_fifo_ptr.sv | 42 ++++
 rtl/ram_dp_fifo_ctrl.sv | 151 +++++++++++++++
 tb/tb_ram_dp_fifo_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_fifo_pkg.sv
// ---------------------------------------------------------------------------
// ram_fifo_pkg
// Shared sizing constants and types for the RAM_DP_TRUE FIFO controller.
//   DW/AW/DEPTH/CW : data width, address width, word count, count width
//   AE_DEF/AF_DEF  : default almost-empty / almost-full thresholds
// ---------------------------------------------------------------------------
package ram_fifo_pkg;

    localparam int DW     = 2;
    localparam int AW     = 13;
    localparam int DEPTH  = 8192;
    localparam int CW     = 14;
    localparam int AE_DEF = 16;
    localparam int AF_DEF = 8176;

    typedef logic [AW-1:0] addr_t;
    typedef logic [DW-1:0] data_t;
    typedef logic [CW-1:0] cnt_t;

endpackage

// File: rtl/ram_fifo_ptr.sv
// ---------------------------------------------------------------------------
// ram_fifo_ptr
// Wrapping circular-buffer pointer. Advances by one when inc_i is high and
// wraps naturally modulo 2**AW (all-ones -> 0).
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset, pointer returns to 0
//   inc_i  : advance the pointer at the next clock edge
//   ptr_o  : current pointer value
// ---------------------------------------------------------------------------
module ram_fifo_ptr
    import ram_fifo_pkg::*;
#(
    parameter int AW = ram_fifo_pkg::AW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          inc_i,
    output logic [AW-1:0] ptr_o
);

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/ram_dp_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// ram_dp_fifo_ctrl
// Single-clock FIFO controller driving an external true dual-port RAM
// (registered address/data-in, unregistered output). Port A writes, port B
// reads; the controller owns pointers, occupancy count and flags.
// Optional feature macro: RAM_FIFO_ALMOST_EN adds AE_LVL/AF_LVL parameters and
// registered AlmostEmpty/AlmostFull outputs.
// Ports:
//   Clock, Reset          : clock, asynchronous active-high reset
//   WrEn, WrData, Full    : producer side
//   RdEn, RdData, RdValid : consumer side (RdData valid one cycle after RdEn)
//   Empty, Count          : occupancy status, Count in 0..DEPTH
//   Overflow, Underflow   : sticky error flags, cleared by ClrErr
//   AlmostEmpty/Full      : only with RAM_FIFO_ALMOST_EN
//   RamAddrA/DataA/WrA/EnA: RAM port A (write)
//   RamAddrB/EnB, RamQB   : RAM port B (read)
//   RamRstA, RamRstB      : RAM output resets, follow Reset
// ---------------------------------------------------------------------------
module ram_dp_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int DW     = ram_fifo_pkg::DW,
    parameter int AW     = ram_fifo_pkg::AW,
    parameter int DEPTH  = ram_fifo_pkg::DEPTH,
`ifdef RAM_FIFO_ALMOST_EN
    parameter int AE_LVL = ram_fifo_pkg::AE_DEF,
    parameter int AF_LVL = ram_fifo_pkg::AF_DEF,
`endif
    parameter int CW     = ram_fifo_pkg::CW
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          WrEn,
    input  logic [DW-1:0] WrData,
    output logic          Full,
    input  logic          RdEn,
    output logic [DW-1:0] RdData,
    output logic          RdValid,
    output logic          Empty,
    output logic [CW-1:0] Count,
    output logic          Overflow,
    output logic          Underflow,
    input  logic          ClrErr,
`ifdef RAM_FIFO_ALMOST_EN
    output logic          AlmostEmpty,
    output logic          AlmostFull,
`endif
    output logic [AW-1:0] RamAddrA,
    output logic [DW-1:0] RamDataA,
    output logic          RamWrA,
    output logic          RamEnA,
    output logic [AW-1:0] RamAddrB,
    output logic          RamEnB,
    input  logic [DW-1:0] RamQB,
    output logic          RamRstA,
    output logic          RamRstB
);

    logic [CW-1:0] count_q, count_d;
    logic          rdv_q;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          wr_acc, rd_acc;
    logic          full, empty;
    logic [AW-1:0] wptr, rptr;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // A read frees a slot in the same edge, so a full FIFO still accepts a
    // write alongside a read. The RAM returns the old word on B in that
    // same-address case, which keeps ordering intact.
    always_comb begin
        rd_acc  = RdEn & ~empty;
        wr_acc  = WrEn & (~full | rd_acc);
        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CW'(1);
        end
        // A fresh error in the ClrErr cycle takes priority over the clear.
        ovf_d = (ovf_q & ~ClrErr) | (WrEn & full & ~rd_acc);
        unf_d = (unf_q & ~ClrErr) | (RdEn & empty);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count_q <= '0;
            rdv_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            rdv_q   <= rd_acc;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

`ifdef RAM_FIFO_ALMOST_EN
    logic ae_q, af_q;

    // Thresholds are evaluated on the next count so the flags move in the
    // same cycle as Count.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ae_q <= 1'b1;
            af_q <= 1'b0;
        end else begin
            ae_q <= (count_d <= CW'(AE_LVL));
            af_q <= (count_d >= CW'(AF_LVL));
        end
    end

    assign AlmostEmpty = ae_q;
    assign AlmostFull  = af_q;
`endif

    ram_fifo_ptr #(.AW(AW)) u_wptr (
        .clk_i (Clock),
        .rst_i (Reset),
        .inc_i (wr_acc),
        .ptr_o (wptr)
    );

    ram_fifo_ptr #(.AW(AW)) u_rptr (
        .clk_i (Clock),
        .rst_i (Reset),
        .inc_i (rd_acc),
        .ptr_o (rptr)
    );

    assign Full      = full;
    assign Empty     = empty;
    assign Count     = count_q;
    assign RdValid   = rdv_q;
    assign RdData    = RamQB;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;

    assign RamAddrA  = wptr;
    assign RamDataA  = WrData;
    assign RamWrA    = wr_acc;
    assign RamEnA    = wr_acc;
    assign RamAddrB  = rptr;
    assign RamEnB    = rd_acc;
    assign RamRstA   = Reset;
    assign RamRstB   = Reset;

endmodule

// File: tb/tb_ram_dp_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_dp_fifo_ctrl
// Bench for ram_dp_fifo_ctrl with a behavioural RAM_DP_TRUE stand-in and a
// queue-based FIFO reference model.
// Optional feature macro: RAM_FIFO_ALMOST_EN.
// ---------------------------------------------------------------------------
module tb_ram_dp_fifo_ctrl;

    localparam int DEPTH = 8192;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        WrEn = 1'b0, RdEn = 1'b0, ClrErr = 1'b0;
    logic [1:0]  WrData = 2'b00;
    logic        Full, RdValid, Empty, Overflow, Underflow;
    logic [1:0]  RdData;
    logic [13:0] Count;
    logic [12:0] RamAddrA, RamAddrB;
    logic [1:0]  RamDataA;
    logic        RamWrA, RamEnA, RamEnB, RamRstA, RamRstB;
    logic [1:0]  RamQB;
`ifdef RAM_FIFO_ALMOST_EN
    logic        AlmostEmpty, AlmostFull;
`endif

    ram_dp_fifo_ctrl dut (
        .Clock(Clock), .Reset(Reset),
        .WrEn(WrEn), .WrData(WrData), .Full(Full),
        .RdEn(RdEn), .RdData(RdData), .RdValid(RdValid),
        .Empty(Empty), .Count(Count),
        .Overflow(Overflow), .Underflow(Underflow), .ClrErr(ClrErr),
`ifdef RAM_FIFO_ALMOST_EN
        .AlmostEmpty(AlmostEmpty), .AlmostFull(AlmostFull),
`endif
        .RamAddrA(RamAddrA), .RamDataA(RamDataA), .RamWrA(RamWrA), .RamEnA(RamEnA),
        .RamAddrB(RamAddrB), .RamEnB(RamEnB), .RamQB(RamQB),
        .RamRstA(RamRstA), .RamRstB(RamRstB)
    );

    always #5 Clock = ~Clock;

    // RAM_DP_TRUE stand-in: registered address/data; B returns the word held
    // before a same-edge write to the same address.
    logic [1:0] mem [DEPTH];
    always @(posedge Clock) begin
        if (RamEnA && RamWrA) mem[RamAddrA] <= RamDataA;
        if (RamRstB) RamQB <= 2'b00;
        else if (RamEnB) RamQB <= mem[RamAddrB];
    end

    // Reference model
    logic [1:0] q[$];
    bit         m_ov, m_un, m_rv, m_ae, m_af;
    logic [1:0] m_rd;
    int         m_wa, m_ra;
    int         vectors = 0;
    int         miscompares = 0;

    task automatic model_clear();
        q.delete();
        m_ov = 0; m_un = 0; m_rv = 0; m_rd = 2'b00;
        m_wa = 0; m_ra = 0; m_ae = 1; m_af = 0;
    endtask

    // One clock of stimulus; entered and left just after a falling edge.
    task automatic step(input bit wr, input logic [1:0] wd, input bit rd, input bit clr);
        bit full, empty, racc, wacc;
        WrEn = wr; WrData = wd; RdEn = rd; ClrErr = clr;
        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        racc  = rd && !empty;
        wacc  = wr && (!full || racc);
        @(posedge Clock);
        m_rv = racc;
        if (racc) begin
            m_rd = q.pop_front();
            m_ra = (m_ra + 1) % DEPTH;
        end
        if (wacc) begin
            q.push_back(wd);
            m_wa = (m_wa + 1) % DEPTH;
        end
        m_ov = (m_ov && !clr) || (wr && full && !racc);
        m_un = (m_un && !clr) || (rd && empty);
        m_ae = (q.size() <= 16);
        m_af = (q.size() >= DEPTH - 16);
        @(negedge Clock);
        WrEn = 0; RdEn = 0; ClrErr = 0;
    endtask

    task automatic do_reset();
        @(negedge Clock);
        #2 Reset = 1'b1;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        step(0, 2'b00, 0, 0);
        vectors++; if (Count !== 14'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", Count); end
        vectors++; if (Empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b want 1", Empty); end
        vectors++; if (Full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b want 0", Full); end
        vectors++; if (RdValid !== 1'b0) begin miscompares++; $display("FAIL reset_rdvalid got %b want 0", RdValid); end
        vectors++; if ({Overflow, Underflow} !== 2'b00) begin miscompares++; $display("FAIL reset_err got %b want 00", {Overflow, Underflow}); end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) step(1, 2'(i), 0, 0);
        vectors++; if (Count !== 14'd4) begin miscompares++; $display("FAIL basic_count got %0d want 4", Count); end
        for (int i = 0; i < 4; i++) begin
            step(0, 2'b00, 1, 0);
            vectors++; if (RdValid !== 1'b1) begin miscompares++; $display("FAIL basic_rdvalid[%0d] got %b want 1", i, RdValid); end
            vectors++; if (RdData !== 2'(i)) begin miscompares++; $display("FAIL basic_rddata[%0d] got %0d want %0d", i, RdData, i); end
        end
        step(0, 2'b00, 0, 0);
        vectors++; if (RdValid !== 1'b0) begin miscompares++; $display("FAIL basic_rdvalid_end got %b want 0", RdValid); end
        vectors++; if (Empty !== 1'b1) begin miscompares++; $display("FAIL basic_empty got %b want 1", Empty); end
    endtask

    // Pointers start at 4 here, so the fill crosses the 8191 -> 0 wrap.
    task automatic test_fill_wrap();
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) step(1, 2'(m_wa), 0, 0);
        vectors++; if (Full !== 1'b1) begin miscompares++; $display("FAIL fill_full got %b want 1", Full); end
        vectors++; if (Count !== 14'd8192) begin miscompares++; $display("FAIL fill_count got %0d want 8192", Count); end
        WrEn = 1; WrData = 2'b01; #1;
        vectors++; if (RamWrA !== 1'b0) begin miscompares++; $display("FAIL fill_drop_ramwr got %b want 0", RamWrA); end
        step(1, 2'b01, 0, 0);
        vectors++; if (Overflow !== 1'b1) begin miscompares++; $display("FAIL fill_overflow got %b want 1", Overflow); end
        vectors++; if (Count !== 14'd8192) begin miscompares++; $display("FAIL fill_count_ovf got %0d want 8192", Count); end
        step(0, 2'b00, 0, 1);
        vectors++; if (Overflow !== 1'b0) begin miscompares++; $display("FAIL clr_overflow got %b want 0", Overflow); end
        // Simultaneous read and write while full.
        for (int i = 0; i < 10; i++) begin
            step(1, 2'($urandom_range(0, 3)), 1, 0);
            vectors++; if (Count !== 14'd8192 || Overflow !== 1'b0) begin miscompares++; $display("FAIL full_rw[%0d] count %0d ovf %b want 8192 0", i, Count, Overflow); end
            vectors++; if (RdValid !== 1'b1 || RdData !== m_rd) begin miscompares++; $display("FAIL full_rw_data[%0d] got %b/%0d want 1/%0d", i, RdValid, RdData, m_rd); end
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 2'b00, 1, 0);
            if (RdValid !== 1'b1 || RdData !== m_rd) bad++;
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL drain_data got %0d bad words want 0", bad); end
        vectors++; if (Empty !== 1'b1) begin miscompares++; $display("FAIL drain_empty got %b want 1", Empty); end
    endtask

    task automatic test_empty_rw();
        step(1, 2'b11, 1, 0);
        vectors++; if (Count !== 14'd1) begin miscompares++; $display("FAIL empty_rw_count got %0d want 1", Count); end
        vectors++; if (RdValid !== 1'b0) begin miscompares++; $display("FAIL empty_rw_rdvalid got %b want 0", RdValid); end
        vectors++; if (Underflow !== 1'b1) begin miscompares++; $display("FAIL empty_rw_underflow got %b want 1", Underflow); end
        step(0, 2'b00, 0, 1);
        vectors++; if (Underflow !== 1'b0) begin miscompares++; $display("FAIL clr_underflow got %b want 0", Underflow); end
        step(0, 2'b00, 1, 0);
        vectors++; if (RdValid !== 1'b1 || RdData !== 2'b11) begin miscompares++; $display("FAIL empty_rw_read got %b/%0d want 1/3", RdValid, RdData); end
        // Error in the same cycle as ClrErr must win.
        step(0, 2'b00, 1, 1);
        vectors++; if (Underflow !== 1'b1) begin miscompares++; $display("FAIL clr_vs_new_err got %b want 1", Underflow); end
        step(0, 2'b00, 0, 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 4000; n++) begin
            bit wr, rd, clr;
            logic [1:0] wd;
            int wbias;
            wbias = ((n / 500) % 2 == 0) ? 70 : 30;
            wr  = ($urandom_range(0, 99) < wbias);
            rd  = ($urandom_range(0, 99) < 50);
            clr = ($urandom_range(0, 99) < 5);
            wd  = 2'($urandom);
            WrEn = wr; WrData = wd; RdEn = rd; ClrErr = clr; #1;
            vectors++;
            if (RamWrA !== (wr && (q.size() < DEPTH || (rd && q.size() > 0))) ||
                RamEnB !== (rd && q.size() > 0) ||
                RamAddrA !== 13'(m_wa) || RamAddrB !== 13'(m_ra)) begin
                miscompares++;
                $display("FAIL rand_ram[%0d] wr %b en %b aa %0d ab %0d want aa %0d ab %0d", n, RamWrA, RamEnB, RamAddrA, RamAddrB, m_wa, m_ra);
            end
            step(wr, wd, rd, clr);
            vectors++;
            if (Count !== 14'(q.size()) || Empty !== (q.size() == 0) || Full !== (q.size() == DEPTH) ||
                Overflow !== m_ov || Underflow !== m_un || RdValid !== m_rv ||
                (m_rv && RdData !== m_rd)) begin
                miscompares++;
                $display("FAIL rand_state[%0d] cnt %0d e%b f%b o%b u%b v%b d%0d want cnt %0d o%b u%b v%b d%0d",
                         n, Count, Empty, Full, Overflow, Underflow, RdValid, RdData, q.size(), m_ov, m_un, m_rv, m_rd);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 2'(i), 0, 0);
        step(0, 2'b00, 1, 0);
        vectors++; if (Count !== 14'd5 || RdValid !== 1'b1) begin miscompares++; $display("FAIL mid_pre count %0d v %b want 5 1", Count, RdValid); end
        #2 Reset = 1'b1;
        #1;
        vectors++; if (Count !== 14'd0 || Empty !== 1'b1) begin miscompares++; $display("FAIL mid_reset count %0d empty %b want 0 1", Count, Empty); end
        vectors++; if (RdValid !== 1'b0 || RamAddrA !== 13'd0 || RamAddrB !== 13'd0) begin miscompares++; $display("FAIL mid_reset_state v %b aa %0d ab %0d want 0 0 0", RdValid, RamAddrA, RamAddrB); end
        @(negedge Clock);
        Reset = 1'b0;
        model_clear();
        step(1, 2'b10, 0, 0);
        step(0, 2'b00, 1, 0);
        vectors++; if (RdValid !== 1'b1 || RdData !== 2'b10) begin miscompares++; $display("FAIL post_reset_read got %b/%0d want 1/2", RdValid, RdData); end
    endtask

`ifdef RAM_FIFO_ALMOST_EN
    task automatic test_almost();
        do_reset();
        vectors++; if (AlmostEmpty !== 1'b1 || AlmostFull !== 1'b0) begin miscompares++; $display("FAIL almost_reset got %b%b want 10", AlmostEmpty, AlmostFull); end
        for (int i = 0; i < 16; i++) step(1, 2'(i), 0, 0);
        vectors++; if (AlmostEmpty !== 1'b1) begin miscompares++; $display("FAIL almost_empty16 got %b want 1", AlmostEmpty); end
        step(1, 2'b00, 0, 0);
        vectors++; if (AlmostEmpty !== 1'b0) begin miscompares++; $display("FAIL almost_empty17 got %b want 0", AlmostEmpty); end
        while (q.size() < DEPTH - 17) step(1, 2'b01, 0, 0);
        vectors++; if (AlmostFull !== 1'b0) begin miscompares++; $display("FAIL almost_full8175 got %b want 0", AlmostFull); end
        step(1, 2'b01, 0, 0);
        vectors++; if (AlmostFull !== 1'b1 || AlmostFull !== m_af) begin miscompares++; $display("FAIL almost_full8176 got %b want 1", AlmostFull); end
    endtask
`endif

    initial begin
        model_clear();
        #2 Reset = 1'b1;
        test_reset();
        test_basic();
        test_fill_wrap();
        test_empty_rw();
        test_random();
        test_reset_mid();
`ifdef RAM_FIFO_ALMOST_EN
        test_almost();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
